// File: rtl/bm_cpu_pkg.sv
// bm_cpu_pkg: opcodes and instruction-width helper shared by the BondMachine core.
package bm_cpu_pkg;
  localparam int OPW = 3;
  localparam logic [OPW-1:0] OP_INC  = 3'b000;
  localparam logic [OPW-1:0] OP_DEC  = 3'b001;
  localparam logic [OPW-1:0] OP_CLR  = 3'b010;
  localparam logic [OPW-1:0] OP_J    = 3'b011;
  localparam logic [OPW-1:0] OP_JZ   = 3'b100;
  localparam logic [OPW-1:0] OP_R2O  = 3'b101;
  localparam logic [OPW-1:0] OP_NOP  = 3'b110;
  localparam logic [OPW-1:0] OP_HALT = 3'b111;
  function automatic int iw_calc(int r, int aw);
    return OPW + r + aw;
  endfunction
endpackage

// File: rtl/bm_out_port.sv
// bm_out_port: one output port's data register, valid flag and stall indication.
// BM_R2O_STALL_EN makes stall report an unacknowledged pending transfer.
module bm_out_port #(
  parameter int RW = 8
) (
  input  logic          clock_signal,
  input  logic          reset_signal,
  input  logic          wr,
  input  logic          received,
  input  logic [RW-1:0] wdata,
  output logic [RW-1:0] data,
  output logic          valid,
  output logic          stall
);
  always_ff @(posedge clock_signal or negedge reset_signal)
    if (!reset_signal) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr) data <= wdata;
      valid <= wr | (valid & ~received);
    end
`ifdef BM_R2O_STALL_EN
  assign stall = valid & ~received;
`else
  assign stall = 1'b0;
`endif
endmodule

// File: rtl/bm_cpu_multi.sv
// bm_cpu_multi: single-register-file BondMachine core driving N_OUT handshaked output ports.
// Optional BM_R2O_STALL_EN stalls R2O on a port whose previous value is unacknowledged.
module bm_cpu_multi import bm_cpu_pkg::*; #(
  parameter int RW = 8,
  parameter int R = 2,
  parameter int AW = 4,
  parameter int N_OUT = 2,
  localparam int IW = iw_calc(R, AW)
) (
  input  logic                clock_signal,
  input  logic                reset_signal,
  output logic [AW-1:0]       rom_bus,
  input  logic [IW-1:0]       rom_value,
  output logic [N_OUT*RW-1:0] o,
  output logic [N_OUT-1:0]    o_valid,
  input  logic [N_OUT-1:0]    o_received,
  output logic                halted
);
  localparam int OB = N_OUT > 1 ? $clog2(N_OUT) : 1;
  logic [AW-1:0] pc, next_pc, tgt;
  logic [RW-1:0] regs [2**R];
  logic [RW-1:0] rv, rv_next;
  logic [OPW-1:0] op;
  logic [R-1:0] ra;
  logic [OB-1:0] oi;
  logic [N_OUT-1:0] stall_v, wr;
  logic idx_ok, stall, run, reg_we;
  assign op = rom_value[IW-1 -: OPW];
  assign ra = rom_value[IW-4 -: R];
  assign tgt = rom_value[AW-1:0];
  assign oi = rom_value[OB-1:0];
  assign rv = regs[ra];
  assign idx_ok = int'(oi) < N_OUT;
  // a stalled R2O freezes the whole core so the same instruction retries
  assign stall = op == OP_R2O && idx_ok && stall_v[oi];
  assign run = !halted && !stall;
  assign reg_we = run && (op == OP_INC || op == OP_DEC || op == OP_CLR);
  assign rv_next = op == OP_INC ? rv + 1'b1 : op == OP_DEC ? rv - 1'b1 : '0;
  assign next_pc = (op == OP_J || (op == OP_JZ && rv == '0)) ? tgt : op == OP_HALT ? pc : pc + 1'b1;
  assign rom_bus = pc;
  always_ff @(posedge clock_signal or negedge reset_signal)
    if (!reset_signal) begin
      pc     <= '0;
      halted <= 1'b0;
      regs   <= '{default: '0};
    end else if (run) begin
      pc     <= next_pc;
      halted <= op == OP_HALT;
      if (reg_we) regs[ra] <= rv_next;
    end
  for (genvar k = 0; k < N_OUT; k++) begin : g_port
    assign wr[k] = run && op == OP_R2O && idx_ok && oi == OB'(k);
    bm_out_port #(.RW(RW)) u_port (
      .clock_signal(clock_signal),
      .reset_signal(reset_signal),
      .wr(wr[k]),
      .received(o_received[k]),
      .wdata(rv),
      .data(o[k*RW +: RW]),
      .valid(o_valid[k]),
      .stall(stall_v[k])
    );
  end
endmodule

// File: tb/tb_bm_cpu_multi.sv
// tb_bm_cpu_multi: directed and random programs checked against an instruction-level model.
module tb_bm_cpu_multi;
  logic clk = 1'b0;
  logic reset_signal = 1'b0;
  logic [3:0] rom_bus;
  logic [8:0] rom_value;
  logic [11:0] o;
  logic [2:0] o_valid;
  logic [2:0] o_received = 3'b000;
  logic halted;
  logic [8:0] rom [16];
  int tests = 0;
  int fails = 0;
  logic [3:0] m_pc;
  logic [3:0] m_r [4];
  logic [3:0] m_d [3];
  logic [2:0] m_v;
  logic m_h;
  bit rcv_rand = 1'b0;
  logic [2:0] rcv_fix = 3'b000;

  always #5 clk = ~clk;
  assign rom_value = rom[rom_bus];

  bm_cpu_multi #(.RW(4), .R(2), .AW(4), .N_OUT(3)) dut (
    .clock_signal(clk),
    .reset_signal(reset_signal),
    .rom_bus(rom_bus),
    .rom_value(rom_value),
    .o(o),
    .o_valid(o_valid),
    .o_received(o_received),
    .halted(halted)
  );

  function automatic logic [8:0] ins(int op, int r, int t);
    logic [2:0] a = 3'(op);
    logic [1:0] b = 2'(r);
    logic [3:0] c = 4'(t);
    return {a, b, c};
  endfunction

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_v = '0;
    m_h = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    for (int i = 0; i < 3; i++) m_d[i] = '0;
  endtask

  // architectural effect of one clock edge, from the instruction set rules
  task automatic model_step();
    logic [8:0] w;
    int op, ra, oi;
    logic [2:0] nv;
    bit st;
    w = rom[m_pc];
    op = int'(w[8:6]);
    ra = int'(w[5:4]);
    oi = int'(w[1:0]);
    nv = m_v & ~o_received;
    st = 1'b0;
`ifdef BM_R2O_STALL_EN
    st = op == 5 && oi < 3 && m_v[oi] && !o_received[oi];
`endif
    if (!m_h && !st)
      case (op)
        0: begin m_r[ra] = (m_r[ra] + 4'd1) % 16; m_pc = (m_pc + 4'd1) % 16; end
        1: begin m_r[ra] = (m_r[ra] + 4'd15) % 16; m_pc = (m_pc + 4'd1) % 16; end
        2: begin m_r[ra] = 4'd0; m_pc = (m_pc + 4'd1) % 16; end
        3: m_pc = w[3:0];
        4: m_pc = m_r[ra] == 0 ? w[3:0] : (m_pc + 4'd1) % 16;
        5: begin
          if (oi < 3) begin m_d[oi] = m_r[ra]; nv[oi] = 1'b1; end
          m_pc = (m_pc + 4'd1) % 16;
        end
        6: m_pc = (m_pc + 4'd1) % 16;
        default: m_h = 1'b1;
      endcase
    m_v = nv;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      cmp("pc", 32'(rom_bus), 32'(m_pc));
      cmp("o", 32'(o), 32'({m_d[2], m_d[1], m_d[0]}));
      cmp("o_valid", 32'(o_valid), 32'(m_v));
      cmp("halted", 32'(halted), 32'(m_h));
      o_received = rcv_rand ? 3'($urandom) : rcv_fix;
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic load_and_reset();
    reset_signal = 1'b0;
    o_received = 3'b000;
    #3;
    model_reset();
    @(negedge clk);
    reset_signal = 1'b1;
  endtask

  task automatic fill(logic [8:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    fill(ins(7, 0, 0));
    #1;
    cmp("por_pc", 32'(rom_bus), 0);
    cmp("por_valid", 32'(o_valid), 0);
    // counting loop with received tied high, checking wrap at RW=4
    rom[0] = ins(0, 0, 0);
    rom[1] = ins(5, 0, 0);
    rom[2] = ins(3, 0, 0);
    rcv_rand = 1'b0;
    rcv_fix = 3'b111;
    load_and_reset();
    run(44);
    cmp("count15", 32'(o[3:0]), 15);
    cmp("count15_v", 32'(o_valid), 1);
    run(3);
    cmp("count_wrap", 32'(o[3:0]), 0);
    cmp("count_wrap_v", 32'(o_valid), 1);
    #2 reset_signal = 1'b0;
    #1;
    cmp("midrst_pc", 32'(rom_bus), 0);
    cmp("midrst_valid", 32'(o_valid), 0);
    cmp("midrst_o", 32'(o), 0);
    cmp("midrst_halt", 32'(halted), 0);
    // DEC underflow, JZ not taken, HALT freezes PC
    fill(ins(0, 1, 0));
    rom[0] = ins(2, 1, 0);
    rom[1] = ins(1, 1, 0);
    rom[2] = ins(4, 1, 7);
    rom[3] = ins(5, 1, 1);
    rom[4] = ins(7, 0, 0);
    rcv_fix = 3'b000;
    load_and_reset();
    run(8);
    cmp("halt_flag", 32'(halted), 1);
    cmp("halt_pc", 32'(rom_bus), 4);
    cmp("dec_wrap", 32'(o[7:4]), 15);
    cmp("dec_valid", 32'(o_valid), 3'b010);
    // third port held valid until a one-cycle received pulse
    fill(ins(7, 0, 0));
    rom[0] = ins(0, 0, 0);
    rom[1] = ins(5, 0, 2);
    load_and_reset();
    run(5);
    cmp("mp_valid", 32'(o_valid), 3'b100);
    cmp("mp_data", 32'(o), 12'h100);
    rcv_fix = 3'b100;
    run(1);
    cmp("mp_clear", 32'(o_valid), 0);
    rcv_fix = 3'b000;
    run(2);
    cmp("mp_hold", 32'(o_valid), 0);
    cmp("mp_data2", 32'(o), 12'h100);
    // back-to-back R2O to an unacknowledged port
    rom[0] = ins(0, 0, 0);
    rom[1] = ins(5, 0, 0);
    rom[2] = ins(0, 0, 0);
    rom[3] = ins(5, 0, 0);
    load_and_reset();
    run(8);
`ifdef BM_R2O_STALL_EN
    cmp("stall_pc", 32'(rom_bus), 3);
    cmp("stall_data", 32'(o[3:0]), 1);
`else
    cmp("nostall_pc", 32'(rom_bus), 4);
    cmp("nostall_data", 32'(o[3:0]), 2);
`endif
    cmp("b2b_valid", 32'(o_valid), 1);
    rcv_fix = 3'b001;
    run(1);
    cmp("b2b_data", 32'(o[3:0]), 2);
`ifdef BM_R2O_STALL_EN
    cmp("stall_valid_kept", 32'(o_valid), 1);
`endif
    run(2);
    cmp("b2b_halt", 32'(halted), 1);
    // out-of-range port index behaves as NOP
    fill(ins(7, 0, 0));
    rom[0] = ins(0, 0, 0);
    rom[1] = ins(5, 0, 3);
    rcv_fix = 3'b000;
    load_and_reset();
    run(2);
    cmp("oor_pc", 32'(rom_bus), 2);
    cmp("oor_valid", 32'(o_valid), 0);
    run(2);
    cmp("oor_halt", 32'(halted), 1);
    cmp("oor_o", 32'(o), 0);
    // random programs with random acknowledges
    rcv_rand = 1'b1;
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 9'($urandom);
      load_and_reset();
      run(150);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
